edgedetect_stream: RTL and testbench

Streaming 3x3 Sobel edge detector, the parametrised successor to the fixed-window `edgedetect` block. It accepts a raster pixel stream through a valid/ready handshake and keeps two internal line buffers, so the upstream bench or DMA no longer assembles a 3x3 grid. Image width and threshold are set per frame. For every interior window it emits the gradient magnitude and an edge flag; it sits between the image source and the cartoonifier colour/merge stage.

---
 rtl/edgedetect_stream_if.sv | 29 ++
 rtl/edgedetect_stream.sv | 160 ++++++++++++++++
 tb/tb_edgedetect_stream.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/edgedetect_stream_if.sv
// Pixel-in / result-out stream bundle for edgedetect_stream.
// Input pixel width follows EDGEDETECT_STREAM_RGB_EN: {R,G,B} when defined, grey otherwise.
interface edgedetect_stream_if #(
  parameter int unsigned PIX_W = 8,
`ifdef EDGEDETECT_STREAM_RGB_EN
  parameter int unsigned IN_W  = 3 * PIX_W
`else
  parameter int unsigned IN_W  = PIX_W
`endif
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sof;
  logic [IN_W-1:0]   in_pixel;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_W+2:0]  out_mag;
  logic              out_edge;

  modport slave (
    input  in_valid, in_sof, in_pixel, out_ready,
    output in_ready, out_valid, out_mag, out_edge
  );

  modport master (
    output in_valid, in_sof, in_pixel, out_ready,
    input  in_ready, out_valid, out_mag, out_edge
  );
endinterface

// File: rtl/edgedetect_stream.sv
// Streaming 3x3 Sobel edge detector with two internal line buffers.
// Optional feature macro: EDGEDETECT_STREAM_RGB_EN (RGB input reduced to luma
// before the line buffers; grey input when undefined).
module edgedetect_stream #(
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned MAX_COLS = 640,
  parameter int unsigned COL_W    = $clog2(MAX_COLS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COL_W-1:0] i_cols,
  input  logic [PIX_W+2:0] i_threshold,
  edgedetect_stream_if.slave s
);
  localparam int unsigned MAG_W  = PIX_W + 3;
  localparam int unsigned SUM_W  = PIX_W + 2;
  localparam int unsigned ADDR_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d, cols_q, cols_d;
  logic [1:0]         row_q, row_d;
  logic [MAG_W-1:0]   thr_q, thr_d, mag_q, mag_d;
  logic               valid_q, valid_d, flag_q, flag_d;
  // Window columns 1 and 2 from the previous pixel; column 0 is dropped on shift.
  logic [PIX_W-1:0]   wa_q [3];
  logic [PIX_W-1:0]   wa_d [3];
  logic [PIX_W-1:0]   wb_q [3];
  logic [PIX_W-1:0]   wb_d [3];
  logic [PIX_W-1:0]   lb0_q [MAX_COLS];
  logic [PIX_W-1:0]   lb1_q [MAX_COLS];

  logic               in_ready_c, acc_c, take_c, emit_c;
  logic [PIX_W-1:0]   pix_c, lb0_rd_c, lb1_rd_c;
  logic [COL_W-1:0]   col_cur_c, cols_cur_c;
  logic [1:0]         row_cur_c;
  logic [MAG_W-1:0]   thr_cur_c, mag_c;
  logic [ADDR_W-1:0]  addr_c;

  // Pixel presented to the line buffers.
`ifdef EDGEDETECT_STREAM_RGB_EN
  logic [SUM_W-1:0]   luma_sum_c;
  always_comb begin
    luma_sum_c = SUM_W'(s.in_pixel[3*PIX_W-1 -: PIX_W])
               + (SUM_W'(s.in_pixel[2*PIX_W-1 -: PIX_W]) << 1)
               + SUM_W'(s.in_pixel[PIX_W-1:0]);
    pix_c      = PIX_W'(luma_sum_c >> 2);
  end
`else
  always_comb begin
    pix_c = s.in_pixel;
  end
`endif

  // Handshake, SOF-overridden frame context and line-buffer read.
  always_comb begin
    in_ready_c = !valid_q || s.out_ready;
    acc_c      = s.in_valid && in_ready_c;
    take_c     = acc_c && (s.in_sof || (state_q == RUN));
    col_cur_c  = s.in_sof ? '0 : col_q;
    row_cur_c  = s.in_sof ? '0 : row_q;
    cols_cur_c = s.in_sof ? i_cols : cols_q;
    thr_cur_c  = s.in_sof ? i_threshold : thr_q;
    addr_c     = ADDR_W'(col_cur_c);
    lb0_rd_c   = lb0_q[addr_c];
    lb1_rd_c   = lb1_q[addr_c];
    emit_c     = take_c && (row_cur_c == 2'd2) && (col_cur_c >= COL_W'(2));
  end

  // Sobel magnitude on the window after this pixel's shift.
  logic [MAG_W-1:0]        sxl_c, sxr_c, syt_c, syb_c, ax_c, ay_c;
  logic signed [MAG_W-1:0] gx_c, gy_c;
  always_comb begin
    sxl_c = MAG_W'(wa_q[0]) + (MAG_W'(wa_q[1]) << 1) + MAG_W'(wa_q[2]);
    sxr_c = MAG_W'(lb1_rd_c) + (MAG_W'(lb0_rd_c) << 1) + MAG_W'(pix_c);
    syt_c = MAG_W'(wa_q[0]) + (MAG_W'(wb_q[0]) << 1) + MAG_W'(lb1_rd_c);
    syb_c = MAG_W'(wa_q[2]) + (MAG_W'(wb_q[2]) << 1) + MAG_W'(pix_c);
    gx_c  = $signed(sxr_c) - $signed(sxl_c);
    gy_c  = $signed(syb_c) - $signed(syt_c);
    ax_c  = gx_c[MAG_W-1] ? MAG_W'(-gx_c) : MAG_W'(gx_c);
    ay_c  = gy_c[MAG_W-1] ? MAG_W'(-gy_c) : MAG_W'(gy_c);
    mag_c = ax_c + ay_c;
  end

  // Next state: frame FSM, counters, window shift and output register.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cols_d  = cols_q;
    thr_d   = thr_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    valid_d = valid_q;
    mag_d   = mag_q;
    flag_d  = flag_q;
    if (take_c) begin
      state_d = RUN;
      cols_d  = cols_cur_c;
      thr_d   = thr_cur_c;
      wa_d    = wb_q;
      wb_d[0] = lb1_rd_c;
      wb_d[1] = lb0_rd_c;
      wb_d[2] = pix_c;
      if (col_cur_c == cols_cur_c - COL_W'(1)) begin
        col_d = '0;
        row_d = (row_cur_c == 2'd2) ? 2'd2 : row_cur_c + 2'd1;
      end else begin
        col_d = col_cur_c + COL_W'(1);
        row_d = row_cur_c;
      end
    end
    if (in_ready_c) begin
      valid_d = emit_c;
      mag_d   = emit_c ? mag_c : '0;
      flag_d  = emit_c && (mag_c > thr_cur_c);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      cols_q  <= COL_W'(MAX_COLS);
      thr_q   <= '0;
      valid_q <= 1'b0;
      mag_q   <= '0;
      flag_q  <= 1'b0;
      wa_q    <= '{default: '0};
      wb_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cols_q  <= cols_d;
      thr_q   <= thr_d;
      valid_q <= valid_d;
      mag_q   <= mag_d;
      flag_q  <= flag_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
    end
  end

  // Line buffers: lb0 holds the previous row, lb1 the one before; never cleared.
  always_ff @(posedge clk) begin
    if (take_c) begin
      lb1_q[addr_c] <= lb0_rd_c;
      lb0_q[addr_c] <= pix_c;
    end
  end

  assign s.in_ready  = in_ready_c;
  assign s.out_valid = valid_q;
  assign s.out_mag   = mag_q;
  assign s.out_edge  = flag_q;
endmodule

// File: tb/tb_edgedetect_stream.sv
// Scoreboard bench for edgedetect_stream: a frame-image model pushes expected
// results on each accepted pixel; a monitor pops them on each output transfer.
module tb_edgedetect_stream;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned MAX_COLS = 640;
  localparam int unsigned COL_W    = $clog2(MAX_COLS + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [COL_W-1:0] cols_i;
  logic [PIX_W+2:0] thr_i;

  edgedetect_stream_if #(.PIX_W(PIX_W)) bus ();

  edgedetect_stream #(.PIX_W(PIX_W), .MAX_COLS(MAX_COLS), .COL_W(COL_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_cols      (cols_i),
    .i_threshold (thr_i),
    .s           (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PIX_W+2:0] mag;
    logic             flag;
  } res_t;

  res_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_out = 0;
  bit   bp_arm = 1'b0;

  int   img [0:63][0:15];
  int   pat [0:15];
  int   m_row, m_col, m_cols, m_thr;
  bit   m_run = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: keep the whole frame image and evaluate Sobel directly on it.
  function automatic void model_accept(input int pix, input bit sof, input int cols, input int thr);
    int gx, gy, mag;
    res_t r;
    if (sof) begin
      m_run = 1'b1; m_row = 0; m_col = 0; m_cols = cols; m_thr = thr;
    end else if (!m_run) begin
      return;
    end
    img[m_row][m_col] = pix;
    if (m_row >= 2 && m_col >= 2) begin
      gx = (img[m_row-2][m_col] + 2*img[m_row-1][m_col] + img[m_row][m_col])
         - (img[m_row-2][m_col-2] + 2*img[m_row-1][m_col-2] + img[m_row][m_col-2]);
      gy = (img[m_row][m_col-2] + 2*img[m_row][m_col-1] + img[m_row][m_col])
         - (img[m_row-2][m_col-2] + 2*img[m_row-2][m_col-1] + img[m_row-2][m_col]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      r.mag  = 11'(mag);
      r.flag = (mag > m_thr);
      exp_q.push_back(r);
    end
    m_col++;
    if (m_col == m_cols) begin
      m_col = 0;
      if (m_row < 63) m_row++;
    end
  endfunction

  task automatic send(input int pix, input bit sof, input int cols, input int thr);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
`ifdef EDGEDETECT_STREAM_RGB_EN
    bus.in_pixel = {PIX_W'(pix), PIX_W'(pix), PIX_W'(pix)};
`else
    bus.in_pixel = PIX_W'(pix);
`endif
    cols_i = COL_W'(cols);
    thr_i  = 11'(thr);
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", t, 0);
    model_accept(pix, sof, cols, thr);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int cols, input int rows, input int thr);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++)
        send(pat[c], (r == 0 && c == 0), cols, thr);
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Output monitor: every transfer must match the head of the scoreboard.
  initial begin
    res_t r;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_out++;
        chk("result_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          r = exp_q.pop_front();
          chk("mag", int'(bus.out_mag), int'(r.mag));
          chk("edge", int'(bus.out_edge), int'(r.flag));
        end
      end
    end
  end

  // Stall the first result after arming for 3 cycles and require it to hold.
  initial begin
    int   hold_mag;
    logic hold_edge;
    forever begin
      @(posedge clk);
      #1;
      if (bp_arm && bus.out_valid) begin
        bp_arm        = 1'b0;
        bus.out_ready = 1'b0;
        hold_mag      = int'(bus.out_mag);
        hold_edge     = bus.out_edge;
        repeat (3) begin
          @(negedge clk);
          chk("bp_valid", int'(bus.out_valid), 1);
          chk("bp_mag", int'(bus.out_mag), hold_mag);
          chk("bp_edge", int'(bus.out_edge), int'(hold_edge));
          chk("bp_in_ready", int'(bus.in_ready), 0);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.in_pixel  = '0;
    bus.out_ready = 1'b1;
    cols_i        = COL_W'(5);
    thr_i         = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_mag", int'(bus.out_mag), 0);
    chk("rst_out_edge", int'(bus.out_edge), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    rst = 1'b0;

    // Flat 5x5 frame of 77.
    for (int c = 0; c < 16; c++) pat[c] = 77;
    base = n_out;
    send_frame(5, 5, 0);
    drain();
    chk("flat_count", n_out - base, 9);

    // Vertical step with a stalled first result.
    pat[0] = 0; pat[1] = 0; pat[2] = 200; pat[3] = 200; pat[4] = 200;
    base   = n_out;
    bp_arm = 1'b1;
    send_frame(5, 4, 799);
    drain();
    chk("step_count", n_out - base, 6);
    chk("bp_consumed", int'(bp_arm), 0);

    // Max gradient at both sides of the threshold.
    pat[0] = 0; pat[1] = 0; pat[2] = 255;
    base = n_out;
    send_frame(3, 3, 1019);
    drain();
    chk("maxgrad_1019_count", n_out - base, 1);
    base = n_out;
    send_frame(3, 3, 1020);
    drain();
    chk("maxgrad_1020_count", n_out - base, 1);

    // Mid-frame SOF at row 2 col 1 with a new width of 4.
    pat[0] = 0; pat[1] = 0; pat[2] = 200; pat[3] = 200; pat[4] = 200;
    base = n_out;
    for (int i = 0; i < 11; i++) send(pat[i % 5], (i == 0), 5, 799);
    pat[3] = 200;
    send_frame(4, 4, 799);
    drain();
    chk("midsof_count", n_out - base, 4);

    // Reset during row 3 with a result stalled in the output register.
    pat[0] = 0; pat[1] = 0; pat[2] = 200; pat[3] = 200; pat[4] = 200;
    base = n_out;
    for (int i = 0; i < 17; i++) send(pat[i % 5], (i == 0), 5, 799);
    drain();
    bus.out_ready = 1'b0;
    send(pat[2], 1'b0, 5, 799);
    @(negedge clk);
    chk("pending_valid", int'(bus.out_valid), 1);
    rst = 1'b1;
    exp_q.delete();
    m_run = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_out_valid", int'(bus.out_valid), 0);
    chk("rst_mid_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(pat[i % 5], 1'b0, 5, 799);
      @(negedge clk);
      chk("idle_no_out", int'(bus.out_valid), 0);
    end
    drain();
    chk("rst_mid_count", n_out - base, 3);
    base = n_out;
    send_frame(5, 3, 799);
    drain();
    chk("recover_count", n_out - base, 3);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
